dl_fpu_issue_sched: RTL
=======================

# dl_fpu_issue_sched

In-order issue scheduler for the DLFloat16 FPU datapath. It accepts one operation request per cycle over a valid/ready handshake and drives the unit-enable and operands into the shared FPU. It prevents writeback collisions between fixed-latency units through a completion-slot reservation vector, and serialises the iterative divide/sqrt engine. Each completing result is registered and returned with its requester tag and exception flags. The block sits between the instruction front-end and the FPU unit bank plus output mux.

## Interface
- `DIV_LAT`, default 12: latency of div and sqrt in cycles, and their minimum issue interval. Legal range 2..15.
- `TAG_W`, default 4: request tag width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous. Drops all in-flight operations.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when `req_valid & req_ready`.
- `req_unit` in 4: unit code. 0 add_sub, 1 mul, 2 mac, 3 div, 4 sqrt, 5 sign_inv, 6 compare, 7 int2float, 8 float2int. Codes 9–15 are illegal.
- `req_tag` in TAG_W: opaque requester tag.
- `req_op1`, `req_op2`, `req_op3` in 32: operands.
- `fpu_go` out 1: one-cycle launch pulse to the FPU.
- `fpu_ena` out 4: unit code for the launched operation.
- `fpu_op1`, `fpu_op2`, `fpu_op3` out 32: operands, driven in the launch cycle.
- `fpu_result` in 32: muxed FPU result.
- `fpu_excep` in 5: FPU flags {invalid, inexact, overflow, underflow, div_by_zero}.
- `rsp_valid` out 1: result pulse.
- `rsp_tag` out TAG_W: tag of the returning result.
- `rsp_data` out 32: result.
- `rsp_flags` out 5: flags of the returning result.
- `idle` out 1: no operation in flight.

## Operation
- Latency table L(unit): add_sub 2, mul 3, mac 4, div `DIV_LAT`, sqrt `DIV_LAT`, sign_inv 1, compare 1, int2float 2, float2int 2, illegal 1.
- Reservation vector `slot[15:0]`. Bit i set means a result returns i cycles from now.
- Each cycle the vector shifts down by one. A tag pipeline of the same depth shifts alongside it, as does an illegal-marker bit per slot.
- `req_ready = !flush & !slot[L(req_unit)] & !(iterative unit & iter_busy)`.
  - `req_ready` depends combinationally on `req_unit`.
  - The requester holds `req_*` stable until accepted.
- Issue: set `slot[L]` and load `req_tag` into tag stage L. Evaluate after the shift, so a bit landing on L from stage L+1 in the same cycle is a collision and blocks issue.
- Launch: for legal codes, in the issue cycle `fpu_go=1`, `fpu_ena=req_unit`, and `fpu_op*=req_op*`. These signals are combinational from the request.
- Illegal codes: `fpu_go=0`. The result returns through the slot mechanism with `rsp_data=0` and `rsp_flags=5'b10000`.
- Iterative engine: div and sqrt share one engine.
  - Issue of either loads `iter_cnt=DIV_LAT-1`.
  - `iter_busy = (iter_cnt!=0)`.
  - The counter decrements every cycle.
- Completion: when a slot reaches stage 0, register `fpu_result`, `fpu_excep` and the stage-0 tag into `rsp_*`, and pulse `rsp_valid` for one cycle.
- There is no output backpressure. The consumer must accept every `rsp_valid`.
- `idle = (slot==0) & !iter_busy & !rsp_valid`.
- `flush`:
  - Clears `slot`, `iter_cnt` and the tags in the same edge.
  - Suppresses any `rsp_valid` that would appear on the next cycle.
  - Holds `req_ready=0` during the flush cycle.
  - A request presented with flush high is not accepted.

## Timing
- Issue at edge t (handshake in cycle t): the FPU presents its result in cycle t+L, and `rsp_valid` is high in cycle t+L+1.
- Throughput is one issue per cycle when there are no slot collisions. Iterative ops have a minimum issue interval of `DIV_LAT` cycles.
- Simultaneous issue and completion in one cycle are both honoured.
- Reset values: `req_ready` follows its equation with an empty state (1 for legal idle units). `fpu_go=0`, `rsp_valid=0`, `rsp_tag=0`, `rsp_data=0`, `rsp_flags=0`, `idle=1`.
- Reset mid-operation discards all in-flight results. No `rsp_valid` is produced for them after reset release.

## Test plan
- add_sub, tag 3, issued cycle 0 -> `fpu_go=1`, `fpu_ena=0` in cycle 0; `rsp_valid=1`, `rsp_tag=3` in cycle 3; `idle=1` in cycle 4.
- mul issued cycle 0 (slot 3), then add_sub requested cycle 1 -> `req_ready=0` in cycle 1 (collision at cycle 3). add issues cycle 2. Responses in cycles 4 and 5 in mul-then-add order.
- div issued cycle 0, sqrt requested from cycle 1 -> `req_ready=0` for cycles 1–11. sqrt issues cycle 12. Responses in cycles 13 and 25. A sign_inv issued in cycle 1 still completes in cycle 3.
- unit 12, tag 7 -> accepted, `fpu_go=0`. `rsp_valid` in cycle 2 with `rsp_flags=5'b10000`, `rsp_data=0`, `rsp_tag=7`.
- Three ops in flight, `flush` in cycle 2 -> no `rsp_valid` afterwards, `idle=1` in cycle 3, a new add accepted in cycle 3.
- `rst_n` low in cycle 5 with div in flight -> outputs at reset values asynchronously. No `rsp_valid` after release, and a div is accepted immediately.

Source files
------------

// File: rtl/dl_fpu_issue_sched_if.sv
// dl_fpu_issue_sched_if
//   Bundles the request handshake, the FPU launch/return bus and the
//   response bus of the DLFloat16 issue scheduler.
//   slave  : the scheduler side (takes requests, drives the FPU and responses)
//   master : the environment side (front-end, FPU bank and result consumer)
// Signals:
//   flush                     synchronous drop of all in-flight operations
//   req_valid/req_ready       request handshake
//   req_unit/req_tag/req_op*  unit code, opaque tag, operands
//   fpu_go/fpu_ena/fpu_op*    launch pulse, unit code, operands to the FPU
//   fpu_result/fpu_excep      muxed FPU result and flags
//   rsp_valid/tag/data/flags  registered result pulse
//   idle                      nothing in flight
interface dl_fpu_issue_sched_if #(
    parameter int TAG_W = 4
);
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_unit;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_op1;
    logic [31:0]      req_op2;
    logic [31:0]      req_op3;
    logic             fpu_go;
    logic [3:0]       fpu_ena;
    logic [31:0]      fpu_op1;
    logic [31:0]      fpu_op2;
    logic [31:0]      fpu_op3;
    logic [31:0]      fpu_result;
    logic [4:0]       fpu_excep;
    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic [4:0]       rsp_flags;
    logic             idle;

    modport slave (
        input  flush, req_valid, req_unit, req_tag, req_op1, req_op2, req_op3,
        input  fpu_result, fpu_excep,
        output req_ready, fpu_go, fpu_ena, fpu_op1, fpu_op2, fpu_op3,
        output rsp_valid, rsp_tag, rsp_data, rsp_flags, idle
    );

    modport master (
        output flush, req_valid, req_unit, req_tag, req_op1, req_op2, req_op3,
        output fpu_result, fpu_excep,
        input  req_ready, fpu_go, fpu_ena, fpu_op1, fpu_op2, fpu_op3,
        input  rsp_valid, rsp_tag, rsp_data, rsp_flags, idle
    );
endinterface

// File: rtl/dl_fpu_issue_sched.sv
// dl_fpu_issue_sched
//   In-order issue scheduler for the DLFloat16 FPU. Accepts one request per
//   cycle, launches it into the shared FPU, reserves the writeback slot of its
//   fixed latency so no two results return in the same cycle, serialises the
//   shared div/sqrt engine, and registers each returning result with its tag.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dl_fpu_issue_sched_if.slave (request, FPU and response buses)
module dl_fpu_issue_sched #(
    parameter int DIV_LAT = 12,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dl_fpu_issue_sched_if.slave        bus
);

    // slot_q[i]: a result is presented by the FPU i cycles from now, so the
    // response register captures it when it reaches stage 0.
    logic [15:0]             slot_q, slot_d;
    logic [15:0][TAG_W-1:0]  tag_q, tag_d;
    logic [15:0]             ill_q, ill_d;
    logic [3:0]              iter_q, iter_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0]        rsp_tag_q, rsp_tag_d;
    logic [31:0]             rsp_data_q, rsp_data_d;
    logic [4:0]              rsp_flags_q, rsp_flags_d;

    logic [3:0] lat, lat_m1;
    logic       is_iter, legal, iter_busy, ready, issue;

    function automatic logic [3:0] lat_of(input logic [3:0] unit);
        case (unit)
            4'd0:       lat_of = 4'd2;
            4'd1:       lat_of = 4'd3;
            4'd2:       lat_of = 4'd4;
            4'd3, 4'd4: lat_of = 4'(DIV_LAT);
            4'd5, 4'd6: lat_of = 4'd1;
            4'd7, 4'd8: lat_of = 4'd2;
            default:    lat_of = 4'd1;   // illegal codes return a flagged dummy
        endcase
    endfunction

    always_comb begin
        lat       = lat_of(bus.req_unit);
        lat_m1    = lat - 4'd1;
        is_iter   = (bus.req_unit == 4'd3) || (bus.req_unit == 4'd4);
        legal     = (bus.req_unit <= 4'd8);
        iter_busy = (iter_q != 4'd0);
        // A bit currently at stage L lands on the new entry's stage after the
        // shift, so it counts as a collision.
        ready     = !bus.flush && !slot_q[lat] && !(is_iter && iter_busy);
        issue     = bus.req_valid && ready;

        slot_d = slot_q >> 1;
        tag_d  = tag_q >> TAG_W;
        ill_d  = ill_q >> 1;
        iter_d = iter_busy ? (iter_q - 4'd1) : 4'd0;

        if (issue) begin
            slot_d[lat_m1] = 1'b1;
            tag_d[lat_m1]  = bus.req_tag;
            ill_d[lat_m1]  = !legal;
            if (is_iter) begin
                iter_d = 4'(DIV_LAT - 1);
            end
        end

        rsp_valid_d = slot_q[0] && !bus.flush;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        if (slot_q[0]) begin
            rsp_tag_d   = tag_q[0];
            rsp_data_d  = ill_q[0] ? 32'd0 : bus.fpu_result;
            rsp_flags_d = ill_q[0] ? 5'b10000 : bus.fpu_excep;
        end

        if (bus.flush) begin
            slot_d = '0;
            tag_d  = '0;
            ill_d  = '0;
            iter_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            tag_q       <= '0;
            ill_q       <= '0;
            iter_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            slot_q      <= slot_d;
            tag_q       <= tag_d;
            ill_q       <= ill_d;
            iter_q      <= iter_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    // Launch is combinational from the request; it is held off while reset
    // is asserted so the FPU never sees a launch the state did not record.
    assign bus.req_ready = ready;
    assign bus.fpu_go    = issue && legal && rst_n;
    assign bus.fpu_ena   = bus.req_unit;
    assign bus.fpu_op1   = bus.req_op1;
    assign bus.fpu_op2   = bus.req_op2;
    assign bus.fpu_op3   = bus.req_op3;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.idle      = (slot_q == 16'd0) && !iter_busy && !rsp_valid_q;

endmodule
